// File: rtl/data_sram_if.sv
// data_sram_if
//   Request/return bundle between the pipeline's data-memory port and the
//   data SRAM responder.
//   Signals:
//     data_sram_en     request valid
//     data_sram_wen    byte write enables, bit i covers wdata[8i+7:8i]; 0 = read
//     data_sram_addr   byte address
//     data_sram_wdata  store data, already lane-aligned
//     data_sram_rdata  registered read data
//     stallreq         stall request towards the stall controller
//   Modports: master (requester side), slave (memory side).
interface data_sram_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, stallreq
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, stallreq
    );
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Memory end of the data_sram interface. Holds 2^ADDR_W 32-bit words,
//   performs byte-lane-merged writes and returns registered read data one
//   cycle after an access completes. LATENCY extra wait cycles per access are
//   modelled by holding stallreq high while the request is pending.
//   Ports:
//     clk     rising-edge clock
//     resetn  asynchronous active-low reset (array contents are not reset)
//     bus     data_sram_if slave: en/wen/addr/wdata in, rdata/stallreq out
module data_sram_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 0
) (
    input  logic        clk,
    input  logic        resetn,
    data_sram_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              latch_req;

    logic [ADDR_W-1:0] addr_r;
    logic [3:0]        wen_r;
    logic [31:0]       wdata_r;

    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       rdata_q;

    logic [ADDR_W-1:0] idx_in;
    logic              stall_c;
    logic              do_acc;
    logic [ADDR_W-1:0] acc_idx;
    logic [3:0]        acc_wen;
    logic [31:0]       acc_wdata;

    // Address bits outside the word index are deliberately ignored, which
    // makes the array alias modulo 2^(ADDR_W+2) bytes.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};

    assign idx_in = bus.data_sram_addr[ADDR_W+1:2];

    // State register and latched request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_r  <= '0;
            wen_r   <= 4'd0;
            wdata_r <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (latch_req) begin
                addr_r  <= idx_in;
                wen_r   <= bus.data_sram_wen;
                wdata_r <= bus.data_sram_wdata;
            end
        end
    end

    // Next-state logic. With LATENCY==0 the machine never leaves IDLE.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        latch_req = 1'b0;
        case (state)
            IDLE: begin
                if (LATENCY != 0 && bus.data_sram_en) begin
                    state_nx  = WAIT;
                    cnt_nx    = 4'(LATENCY - 1);
                    latch_req = 1'b1;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    // The en seen in this cycle is the held copy of the
                    // request being completed, so it is not re-accepted.
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: stall request and selection of the access that happens
    // at the coming edge (live inputs for LATENCY==0, latched ones otherwise).
    always_comb begin
        stall_c   = 1'b0;
        do_acc    = 1'b0;
        acc_idx   = idx_in;
        acc_wen   = bus.data_sram_wen;
        acc_wdata = bus.data_sram_wdata;
        if (LATENCY == 0) begin
            do_acc = bus.data_sram_en;
        end else begin
            case (state)
                IDLE: stall_c = bus.data_sram_en;
                WAIT: begin
                    if (cnt != 4'd0) begin
                        stall_c = 1'b1;
                    end else begin
                        do_acc    = 1'b1;
                        acc_idx   = addr_r;
                        acc_wen   = wen_r;
                        acc_wdata = wdata_r;
                    end
                end
                default: stall_c = 1'b0;
            endcase
        end
    end

    // Reset drops any in-flight access and forces stallreq low immediately.
    assign bus.stallreq        = stall_c & resetn;
    assign bus.data_sram_rdata = rdata_q;

    // Array write port: only enabled lanes are updated, the rest are kept.
    always_ff @(posedge clk) begin
        if (do_acc && resetn) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wen[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data register: changes only when a read completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'd0;
        end else if (do_acc && acc_wen == 4'd0) begin
            rdata_q <= mem[acc_idx];
        end
    end

endmodule
